// File: rtl/sram_host_port.sv
// Initiator side of the single-port SRAM macro interface: registers core requests onto
// the macro pins and returns in-order responses through a credit-protected FIFO.
module sram_host_port #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_we_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_we_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0] sram_wmask_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

  localparam int unsigned MASK_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned PIPE_STAGES = READ_LATENCY + 1;
  localparam int unsigned CNT_WIDTH   = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_WIDTH   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(RSP_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(RSP_DEPTH);

  logic                   accept_c;
  logic                   pop_c;
  logic                   push_c;
  logic                   push_we_c;
  logic [DATA_WIDTH-1:0]  push_data_c;
  logic [CNT_WIDTH-1:0]   outst_next_c;

  logic [PIPE_STAGES-1:0] pipe_vld_q;
  logic [PIPE_STAGES-1:0] pipe_we_q;
  logic [DATA_WIDTH-1:0]  mem_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]   mem_we_q;
  logic [PTR_WIDTH-1:0]   wptr_q;
  logic [PTR_WIDTH-1:0]   rptr_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [CNT_WIDTH-1:0]   outst_q;

  assign accept_c    = req_valid_i & req_ready_o;
  assign pop_c       = rsp_valid_o & rsp_ready_i;
  assign push_c      = pipe_vld_q[READ_LATENCY];
  assign push_we_c   = pipe_we_q[READ_LATENCY];
  assign push_data_c = push_we_c ? '0 : sram_rdata_i;

  assign rsp_valid_o = (count_q != '0);
  assign rsp_rdata_o = mem_q[rptr_q];
  assign rsp_we_o    = mem_we_q[rptr_q];

  // Macro pins: one active cycle per accepted request, payload held while idle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      sram_wmask_o <= '0;
    end else if (accept_c) begin
      sram_csb_o   <= 1'b0;
      sram_web_o   <= ~req_we_i;
      sram_addr_o  <= req_addr_i;
      sram_wdata_o <= req_wdata_i;
      sram_wmask_o <= req_wmask_i;
    end else begin
      sram_csb_o   <= 1'b1;
      sram_web_o   <= 1'b1;
    end
  end

  // Tag pipe: the last stage lines up with valid macro read data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      pipe_we_q  <= '0;
    end else begin
      pipe_vld_q <= {pipe_vld_q[PIPE_STAGES-2:0], accept_c};
      pipe_we_q  <= {pipe_we_q[PIPE_STAGES-2:0], req_we_i};
    end
  end

  // Response FIFO
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      mem_we_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wptr_q]    <= push_data_c;
        mem_we_q[wptr_q] <= push_we_c;
        wptr_q           <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_WIDTH'(1);
      end
      if (pop_c) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_WIDTH'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CNT_WIDTH'(1);
      end
    end
  end

  // Credits: pipe entries plus FIFO entries only change on accept and pop
  always_comb begin
    outst_next_c = outst_q;
    if (accept_c && !pop_c) begin
      outst_next_c = outst_q + CNT_WIDTH'(1);
    end else if (!accept_c && pop_c) begin
      outst_next_c = outst_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_q     <= '0;
      req_ready_o <= 1'b0;
    end else begin
      outst_q     <= outst_next_c;
      req_ready_o <= (outst_next_c < DEPTH_CNT);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_c && !pop_c && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_sram_host_port.sv
// Directed bench for sram_host_port with a behavioural single-port SRAM macro
// (capture on the rising edge, read data one cycle later).
module tb_sram_host_port;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [11:0] req_addr_i;
  logic        req_we_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_we_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic [11:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [3:0]  sram_wmask_o;
  logic [31:0] sram_rdata_i;

  logic [31:0] sram_mem [0:4095];
  int checks;
  int errors;

  sram_host_port dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_wdata_i  (req_wdata_i),
    .req_wmask_i  (req_wmask_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_we_o     (rsp_we_o),
    .sram_csb_o   (sram_csb_o),
    .sram_web_o   (sram_web_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_wmask_o (sram_wmask_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Macro model
  always @(posedge clk_i) begin
    if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) sram_mem[sram_addr_o][b*8 +: 8] = sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (sram_csb_o !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b expected 1", sram_csb_o); end
    checks++; if (sram_web_o !== 1'b1) begin errors++; $display("FAIL reset_web: got %b expected 1", sram_web_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'h0 || rsp_we_o !== 1'b0) begin errors++; $display("FAIL reset_rsp: got we=%b rdata=%h expected 0/0", rsp_we_o, rsp_rdata_o); end
    checks++; if (sram_addr_o !== 12'h0 || sram_wdata_o !== 32'h0 || sram_wmask_o !== 4'h0) begin errors++; $display("FAIL reset_pins: got addr=%h wdata=%h mask=%h expected 0", sram_addr_o, sram_wdata_o, sram_wmask_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready_o); end
  endtask

  task automatic test_write_read();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 12'h010; req_wdata_i = 32'hDEADBEEF; req_wmask_i = 4'hF;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", req_ready_o); end
    @(negedge clk_i);
    checks++; if ({sram_csb_o, sram_web_o} !== 2'b00) begin errors++; $display("FAIL wr_pins: got csb/web=%b expected 00", {sram_csb_o, sram_web_o}); end
    checks++; if (sram_addr_o !== 12'h010 || sram_wdata_o !== 32'hDEADBEEF || sram_wmask_o !== 4'hF) begin errors++; $display("FAIL wr_payload: got addr=%h wdata=%h mask=%h expected 010/deadbeef/f", sram_addr_o, sram_wdata_o, sram_wmask_o); end
    req_we_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({sram_csb_o, sram_web_o} !== 2'b01) begin errors++; $display("FAIL rd_pins: got csb/web=%b expected 01", {sram_csb_o, sram_web_o}); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_early: got valid=%b expected 0", rsp_valid_o); end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL wr_rsp: got valid=%b we=%b rdata=%h expected 1/1/00000000", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    checks++; if ({sram_csb_o, sram_web_o} !== 2'b11) begin errors++; $display("FAIL idle_pins: got csb/web=%b expected 11", {sram_csb_o, sram_web_o}); end
    @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_rsp: got valid=%b we=%b rdata=%h expected 1/0/deadbeef", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rd_drain: got valid=%b expected 0", rsp_valid_o); end
  endtask

  task automatic test_byte_mask();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 12'h020; req_wdata_i = 32'h11223344; req_wmask_i = 4'hF;
    @(negedge clk_i);
    req_wdata_i = 32'hAABBCCDD; req_wmask_i = 4'h5;
    @(negedge clk_i);
    req_we_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL mask_ack0: got valid=%b we=%b rdata=%h expected 1/1/0", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL mask_ack1: got valid=%b we=%b rdata=%h expected 1/1/0", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b10, 32'h11BB33DD}) begin errors++; $display("FAIL mask_read: got valid=%b we=%b rdata=%h expected 1/0/11bb33dd", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mask_drain: got valid=%b expected 0", rsp_valid_o); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    rsp_ready_i = 1'b1; req_we_i = 1'b0; req_wmask_i = 4'h0;
    for (int c = 0; c < 19; c++) begin
      req_valid_i = (c < 16);
      req_addr_i  = 12'(c);
      if (c < 16) begin
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", c, req_ready_o); end
      end
      @(negedge clk_i);
      if (c >= 2 && c <= 17) begin
        exp = 32'h5A5A0000 + 32'(c - 2);
        checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b10, exp}) begin errors++; $display("FAIL stream_rsp[%0d]: got valid=%b we=%b rdata=%h expected 1/0/%h", c - 2, rsp_valid_o, rsp_we_o, rsp_rdata_o, exp); end
      end else begin
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: got valid=%b expected 0", c, rsp_valid_o); end
      end
    end
  endtask

  task automatic test_backpressure();
    int  sent;
    int  rcv;
    logic acc;
    logic [31:0] exp;
    sent = 0; rcv = 0;
    rsp_ready_i = 1'b0; req_we_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      req_valid_i = 1'b1;
      req_addr_i  = 12'(12'h100 + sent);
      acc = req_ready_o;
      @(negedge clk_i);
      if (acc) sent++;
    end
    checks++; if (sent !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", req_ready_o); end
    checks++; if ({rsp_valid_o, rsp_we_o, rsp_rdata_o} !== {2'b10, 32'h5A5A0100}) begin errors++; $display("FAIL bp_head: got valid=%b we=%b rdata=%h expected 1/0/5a5a0100", rsp_valid_o, rsp_we_o, rsp_rdata_o); end
    repeat (2) @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_rdata_o, req_ready_o} !== {1'b1, 32'h5A5A0100, 1'b0}) begin errors++; $display("FAIL bp_head_stable: got valid=%b rdata=%h ready=%b expected 1/5a5a0100/0", rsp_valid_o, rsp_rdata_o, req_ready_o); end
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      req_valid_i = (sent < 8);
      req_addr_i  = 12'(12'h100 + sent);
      acc = req_valid_i && req_ready_o;
      if (rsp_valid_o) begin
        exp = 32'h5A5A0100 + 32'(rcv);
        checks++; if (rsp_rdata_o !== exp || rsp_we_o !== 1'b0) begin errors++; $display("FAIL bp_drain[%0d]: got we=%b rdata=%h expected 0/%h", rcv, rsp_we_o, rsp_rdata_o, exp); end
        rcv++;
      end
      @(negedge clk_i);
      if (acc) sent++;
    end
    req_valid_i = 1'b0;
    checks++; if (rcv !== 8 || sent !== 8) begin errors++; $display("FAIL bp_total: got sent=%0d received=%0d expected 8/8", sent, rcv); end
    repeat (3) @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got valid=%b expected 0", rsp_valid_o); end
  endtask

  task automatic test_reset_midflight();
    rsp_ready_i = 1'b0; req_we_i = 1'b0; req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr_i = 12'(k);
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++; if ({req_ready_o, rsp_valid_o, sram_csb_o} !== 3'b001) begin errors++; $display("FAIL midrst_state: got ready/valid/csb=%b expected 001", {req_ready_o, rsp_valid_o, sram_csb_o}); end
    rst_ni = 1'b1; rsp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_ghost[%0d]: got valid=%b expected 0", c, rsp_valid_o); end
    end
    checks++; if (dut.count_q !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", dut.count_q); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", req_ready_o); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 4096; i++) sram_mem[i] = 32'h5A5A0000 + 32'(i);
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_wmask_i = '0; rsp_ready_i = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
